// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM stage: op codes, FSM states, bus request.
package mem_access_pkg;

  localparam int XLEN    = 64;
  localparam int REG_AW  = 5;
  localparam int CTRL_W  = 5;
  localparam logic [CTRL_W-1:0] CTRL_STATE_DEFAULT = '0;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LH   = 4'd2,
    MEM_OP_LW   = 4'd3,
    MEM_OP_LD   = 4'd4,
    MEM_OP_LBU  = 4'd5,
    MEM_OP_LHU  = 4'd6,
    MEM_OP_LWU  = 4'd7,
    MEM_OP_SB   = 4'd8,
    MEM_OP_SH   = 4'd9,
    MEM_OP_SW   = 4'd10,
    MEM_OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_WAIT = 2'd2,
    MEM_ST_DONE = 2'd3
  } mem_st_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wstrb;
  } dmem_req_t;

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LD,
                      MEM_OP_LBU, MEM_OP_LHU, MEM_OP_LWU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SD};
  endfunction

  // Strobes are shifted within 8 bits, so a misaligned access simply loses the top lanes.
  function automatic logic [7:0] store_strb(input mem_op_e op, input logic [2:0] a);
    case (op)
      MEM_OP_SB: return 8'h01 << a;
      MEM_OP_SH: return 8'h03 << a;
      MEM_OP_SW: return 8'h0F << a;
      MEM_OP_SD: return 8'hFF;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [2:0] a);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return a[0];
      MEM_OP_LW, MEM_OP_LWU, MEM_OP_SW: return a[1:0] != 2'b00;
      MEM_OP_LD, MEM_OP_SD:             return a != 3'b000;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Combinational load formatter: pick the addressed bytes and sign/zero-extend by op.
module mem_access_load_extract
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  mem_op_e         op_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;

  always_comb begin
    // Right shift fills with zeros: misaligned lanes past bit 63 read as 0.
    sh = rdata_i >> {off_i, 3'b000};
    case (op_i)
      MEM_OP_LB:  data_o = {{56{sh[7]}},  sh[7:0]};
      MEM_OP_LBU: data_o = {56'd0,        sh[7:0]};
      MEM_OP_LH:  data_o = {{48{sh[15]}}, sh[15:0]};
      MEM_OP_LHU: data_o = {48'd0,        sh[15:0]};
      MEM_OP_LW:  data_o = {{32{sh[31]}}, sh[31:0]};
      MEM_OP_LWU: data_o = {32'd0,        sh[31:0]};
      default:    data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: ALU pass-through, or a req/gnt/rvalid data-memory access with stall.
// Define MEM_MISALIGN_CHECK_EN to fault misaligned H/W/D accesses instead of issuing them.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [CTRL_W-1:0] ctrl_signal_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [7:0]        dmem_wstrb_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stallreq_o,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_st_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            bus_err_q, bus_err_d;
  dmem_req_t       req_q, req_d;
  logic [2:0]      off_q, off_d;
  mem_op_e         op_q, op_d;

  mem_op_e         op_in;
  logic [2:0]      a_in;
  logic            mem_in, misalign;
  dmem_req_t       new_req, bus_req;
  logic [XLEN-1:0] ld_val;

  always_comb begin
    op_in         = mem_op_e'(mem_op_i);
    a_in          = mem_addr_i[2:0];
    mem_in        = is_load(op_in) || is_store(op_in);
    new_req.we    = is_store(op_in);
    new_req.addr  = {mem_addr_i[XLEN-1:3], 3'b000};
    new_req.wdata = store_data_i << {a_in, 3'b000};
    new_req.wstrb = store_strb(op_in, a_in);
`ifdef MEM_MISALIGN_CHECK_EN
    misalign      = is_misaligned(op_in, a_in);
`else
    misalign      = 1'b0;
`endif
  end

  mem_access_load_extract u_ld (
    .rdata_i (dmem_rdata_i),
    .off_i   (off_q),
    .op_i    (op_q),
    .data_o  (ld_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    err_d     = err_q;
    bus_err_d = 1'b0;
    req_d     = req_q;
    off_d     = off_q;
    op_d      = op_q;
    case (state_q)
      MEM_ST_IDLE: if (mem_in) begin
        req_d    = new_req;
        off_d    = a_in;
        op_d     = op_in;
        err_d    = 1'b0;
        result_d = '0;
        cnt_d    = '0;
        if (misalign) begin
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = MEM_ST_DONE;
        end else if (dmem_gnt_i) begin
          state_d = new_req.we ? MEM_ST_DONE : MEM_ST_WAIT;
        end else begin
          state_d = MEM_ST_REQ;
        end
      end
      MEM_ST_REQ: if (dmem_gnt_i) begin
        cnt_d   = '0;
        state_d = req_q.we ? MEM_ST_DONE : MEM_ST_WAIT;
      end
      MEM_ST_WAIT: begin
        if (dmem_rvalid_i) begin
          result_d = ld_val;
          state_d  = MEM_ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = '0;
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = MEM_ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_ST_DONE: if (ctrl_signal_i == CTRL_STATE_DEFAULT) state_d = MEM_ST_IDLE;
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MEM_ST_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
      req_q     <= '0;
      off_q     <= '0;
      op_q      <= MEM_OP_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      off_q     <= off_d;
      op_q      <= op_d;
    end
  end

  // Outputs are qualified by rst so nothing leaks from the live inputs during reset.
  always_comb begin
    bus_req      = (state_q == MEM_ST_IDLE) ? new_req : req_q;
    dmem_req_o   = rst && (((state_q == MEM_ST_IDLE) && mem_in && !misalign) ||
                           (state_q == MEM_ST_REQ));
    dmem_we_o    = dmem_req_o && bus_req.we;
    dmem_addr_o  = dmem_req_o ? bus_req.addr  : '0;
    dmem_wdata_o = dmem_req_o ? bus_req.wdata : '0;
    dmem_wstrb_o = dmem_req_o ? bus_req.wstrb : '0;
    rd_addr_o    = '0;
    wreg_o       = 1'b0;
    wdata_o      = '0;
    stallreq_o   = 1'b0;
    bus_err_o    = rst && bus_err_q;
    if (rst) begin
      case (state_q)
        MEM_ST_IDLE: begin
          if (mem_in) begin
            stallreq_o = 1'b1;
          end else begin
            rd_addr_o = rd_addr_i;
            wreg_o    = wreg_i;
            wdata_o   = wdata_i;
          end
        end
        MEM_ST_REQ, MEM_ST_WAIT: stallreq_o = 1'b1;
        MEM_ST_DONE: begin
          rd_addr_o = rd_addr_i;
          wreg_o    = wreg_i && !req_q.we && !err_q;
          wdata_o   = req_q.we ? wdata_i : result_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT_CYCLES=4); expected values are hand-computed.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LW = 4'd3, OP_LD = 4'd4,
                         OP_SH = 4'd9, OP_SW = 4'd10, OP_SD = 4'd11;
  localparam logic [CTRL_W-1:0] CTRL_DEF = '0, CTRL_HOLD = CTRL_W'(1);

  logic              clk = 1'b0, rst;
  logic [REG_AW-1:0] rd_addr_i, rd_addr_o;
  logic              wreg_i, wreg_o;
  logic [63:0]       wdata_i, wdata_o, mem_addr_i, store_data_i, dmem_rdata_i;
  logic [3:0]        mem_op_i;
  logic [CTRL_W-1:0] ctrl_signal_i;
  logic              dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [63:0]       dmem_addr_o, dmem_wdata_o;
  logic [7:0]        dmem_wstrb_o;
  logic              stallreq_o, bus_err_o;
  int                n_chk = 0, n_err = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .ctrl_signal_i(ctrl_signal_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] sd);
    mem_op_i = o; mem_addr_i = a; store_data_i = sd;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [63:0] rd);
    dmem_gnt_i = g; dmem_rvalid_i = rv; dmem_rdata_i = rd;
  endtask

  initial begin
    rst = 1'b0; rd_addr_i = '0; wreg_i = 1'b0; wdata_i = '0; ctrl_signal_i = CTRL_DEF;
    op(OP_LD, 64'h40, 64'h0); bus(1'b0, 1'b0, 64'h0);
    #2;
    chk("rst_req",   dmem_req_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_err",   bus_err_o, 0);
    op(OP_NONE, 64'h0, 64'h0);
    settle; rst = 1'b1;
    next;

    // pass-through
    rd_addr_i = 5'd5; wreg_i = 1'b1; wdata_i = 64'h1234;
    settle;
    chk("t1_wdata", wdata_o, 64'h1234);
    chk("t1_rd",    rd_addr_o, 5);
    chk("t1_wreg",  wreg_o, 1);
    chk("t1_stall", stallreq_o, 0);
    chk("t1_req",   dmem_req_o, 0);
    next;

    // LB sign-extend; rvalid in the gnt cycle must be ignored
    rd_addr_i = 5'd7; op(OP_LB, 64'h1003, 64'h0); bus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    settle;
    chk("t2_c1_req",   dmem_req_o, 1);
    chk("t2_c1_addr",  dmem_addr_o, 64'h1000);
    chk("t2_c1_we",    dmem_we_o, 0);
    chk("t2_c1_stall", stallreq_o, 1);
    next; bus(1'b0, 1'b0, 64'h0);
    settle;
    chk("t2_c2_stall", stallreq_o, 1);
    chk("t2_c2_req",   dmem_req_o, 0);
    next; bus(1'b0, 1'b1, 64'h0000_0000_8000_0000);
    settle;
    chk("t2_c3_stall", stallreq_o, 1);
    next; bus(1'b0, 1'b0, 64'h0);
    settle;
    chk("t2_c4_stall", stallreq_o, 0);
    chk("t2_c4_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("t2_c4_wreg",  wreg_o, 1);
    chk("t2_c4_rd",    rd_addr_o, 7);
    next; op(OP_NONE, 64'h0, 64'h0);

    // SH with grant withheld 4 cycles
    wdata_i = 64'h55; op(OP_SH, 64'h2006, 64'hABCD);
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("t3_req",   dmem_req_o, 1);
      chk("t3_we",    dmem_we_o, 1);
      chk("t3_addr",  dmem_addr_o, 64'h2000);
      chk("t3_wstrb", dmem_wstrb_o, 8'hC0);
      chk("t3_wdata", dmem_wdata_o, 64'hABCD_0000_0000_0000);
      chk("t3_stall", stallreq_o, 1);
      next;
    end
    dmem_gnt_i = 1'b1;
    settle;
    chk("t3_gnt_req", dmem_req_o, 1);
    next; dmem_gnt_i = 1'b0;
    settle;
    chk("t3_done_stall", stallreq_o, 0);
    chk("t3_done_wreg",  wreg_o, 0);
    chk("t3_done_wdata", wdata_o, 64'h55);
    next; op(OP_NONE, 64'h0, 64'h0);

    // LD completes while ctrl holds MEM_WB
    ctrl_signal_i = CTRL_HOLD; op(OP_LD, 64'h4000, 64'h0); bus(1'b1, 1'b0, 64'h0);
    next; bus(1'b0, 1'b1, 64'h1122_3344_5566_7788);
    next; bus(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ctrl_signal_i = CTRL_DEF;
      settle;
      chk("t4_hold_wdata", wdata_o, 64'h1122_3344_5566_7788);
      chk("t4_hold_req",   dmem_req_o, 0);
      chk("t4_hold_stall", stallreq_o, 0);
      next;
    end
    op(OP_NONE, 64'h0, 64'h0); wdata_i = 64'h77;
    settle;
    chk("t4_idle_wdata", wdata_o, 64'h77);

    // timeout after 4 wait cycles; late rvalid in S_DONE ignored
    next; ctrl_signal_i = CTRL_HOLD; op(OP_LW, 64'h5000, 64'h0); bus(1'b1, 1'b0, 64'h0);
    next; dmem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("t5_wait_stall", stallreq_o, 1);
      chk("t5_wait_err",   bus_err_o, 0);
      next;
    end
    bus(1'b0, 1'b1, 64'hDEAD_BEEF);
    settle;
    chk("t5_err",   bus_err_o, 1);
    chk("t5_wdata", wdata_o, 0);
    chk("t5_wreg",  wreg_o, 0);
    chk("t5_stall", stallreq_o, 0);
    next; bus(1'b0, 1'b0, 64'h0);
    settle;
    chk("t5_pulse", bus_err_o, 0);
    chk("t5_hold",  wdata_o, 0);
    next; ctrl_signal_i = CTRL_DEF;
    next; op(OP_NONE, 64'h0, 64'h0);

    // reset while in S_REQ drops req with no clock edge
    op(OP_SD, 64'h7000, 64'h1);
    next;
    settle;
    chk("t6_req_before", dmem_req_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_req_rst",   dmem_req_o, 0);
    chk("t6_stall_rst", stallreq_o, 0);
    op(OP_NONE, 64'h0, 64'h0);
    settle; rst = 1'b1;
    next;

    // reset while in S_WAIT; a late rvalid afterwards is ignored
    op(OP_LD, 64'h6000, 64'h0); bus(1'b1, 1'b0, 64'h0);
    next; dmem_gnt_i = 1'b0;
    settle;
    chk("t6_wait_stall", stallreq_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_wait_rst", stallreq_o, 0);
    op(OP_NONE, 64'h0, 64'h0); wdata_i = 64'h99;
    settle; rst = 1'b1;
    next; bus(1'b0, 1'b1, 64'hCAFE);
    settle;
    chk("t6_late_stall", stallreq_o, 0);
    chk("t6_late_wdata", wdata_o, 64'h99);
    chk("t6_late_err",   bus_err_o, 0);
    next; bus(1'b0, 1'b0, 64'h0);
    settle;
    chk("t6_after_stall", stallreq_o, 0);
    next;

    // misaligned LW at 0x3002
    op(OP_LW, 64'h3002, 64'h0);
`ifdef MEM_MISALIGN_CHECK_EN
    settle;
    chk("t7_req",   dmem_req_o, 0);
    chk("t7_stall", stallreq_o, 1);
    next; op(OP_NONE, 64'h0, 64'h0); wdata_i = 64'h1;
    op(OP_LW, 64'h3002, 64'h0);
    settle;
    chk("t7_err",   bus_err_o, 1);
    chk("t7_wreg",  wreg_o, 0);
    chk("t7_wdata", wdata_o, 0);
    next; op(OP_NONE, 64'h0, 64'h0);
    settle;
    chk("t7_pulse", bus_err_o, 0);
    next;
`else
    dmem_gnt_i = 1'b1;
    settle;
    chk("t7_req",  dmem_req_o, 1);
    chk("t7_addr", dmem_addr_o, 64'h3000);
    next; bus(1'b0, 1'b1, 64'hAABB_CCDD_EEFF_0011);
    next; bus(1'b0, 1'b0, 64'h0);
    settle;
    chk("t7_wdata", wdata_o, 64'hFFFF_FFFF_CCDD_EEFF);
    chk("t7_err",   bus_err_o, 0);
    next; op(OP_SW, 64'h3006, 64'h1234_5678);
    settle;
    chk("t7_sw_wstrb", dmem_wstrb_o, 8'hC0);
    chk("t7_sw_wdata", dmem_wdata_o, 64'h5678_0000_0000_0000);
    dmem_gnt_i = 1'b1;
    next; op(OP_NONE, 64'h0, 64'h0); dmem_gnt_i = 1'b0;
    next;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
